// File: rtl/cache_fill_fsm_if.sv
// Bus bundle between the cache miss logic, main memory and the fill engine.
// The slave modport is the fill engine's view; master is the cache/memory side.
interface cache_fill_fsm_if #(
  parameter int ADDR_W = 16
);
  logic              miss_detected;
  logic [ADDR_W-1:0] miss_address;
  logic              memory_data_valid;
  logic [15:0]       memory_data;
  logic              fsm_busy;
  logic              mem_en;
  logic [ADDR_W-1:0] memory_address;
  logic              write_data_array;
  logic              write_tag_array;
  logic [ADDR_W-1:0] fill_address;
  logic [15:0]       fill_data;

  modport master (
    output miss_detected, miss_address, memory_data_valid, memory_data,
    input  fsm_busy, mem_en, memory_address, write_data_array,
           write_tag_array, fill_address, fill_data
  );

  modport slave (
    input  miss_detected, miss_address, memory_data_valid, memory_data,
    output fsm_busy, mem_en, memory_address, write_data_array,
           write_tag_array, fill_address, fill_data
  );
endinterface

// File: rtl/cache_fill_fsm.sv
// Cache miss fill engine: streams one read per word of the aligned line to
// memory, writes each returned word into the data array, then writes the tag.
module cache_fill_fsm #(
  parameter int WORDS_PER_LINE = 8,
  parameter int ADDR_W         = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  cache_fill_fsm_if.slave bus
);

  localparam int OFF_W = $clog2(2 * WORDS_PER_LINE);
  localparam int IDX_W = OFF_W - 1;
  localparam int CNT_W = IDX_W + 1;
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(2 * WORDS_PER_LINE - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] line_base;
  logic [CNT_W-1:0]  issue_cnt;
  logic [IDX_W-1:0]  ret_cnt;
  logic              issue, ret, last_ret;

  assign issue    = (state == BUSY) && (issue_cnt < CNT_W'(WORDS_PER_LINE));
  assign ret      = (state == BUSY) && bus.memory_data_valid;
  assign last_ret = ret && (ret_cnt == IDX_W'(WORDS_PER_LINE - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: defaulting every always_comb output first keeps paths that do not
  // assign it from inferring a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (bus.miss_detected) state_nxt = BUSY;
      BUSY: if (last_ret)          state_nxt = IDLE;
    endcase
  end

  // Miss capture and the issue/return word counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_base <= '0;
      issue_cnt <= '0;
      ret_cnt   <= '0;
    end else if (state == IDLE) begin
      if (bus.miss_detected) begin
        line_base <= bus.miss_address & LINE_MASK;
        issue_cnt <= '0;
        ret_cnt   <= '0;
      end
    end else begin
      if (issue) issue_cnt <= issue_cnt + CNT_W'(1);
      // Wraps back to zero on the final word, ready for the next fill.
      if (ret)   ret_cnt   <= ret_cnt + IDX_W'(1);
    end
  end

  // Word offsets are OR-ed into the aligned base so a line at the top of the
  // address space never carries out; a saturated issue_cnt aliases to the
  // base but mem_en is already low then.
  always_comb begin
    bus.fsm_busy         = 1'b0;
    bus.mem_en           = 1'b0;
    bus.memory_address   = '0;
    bus.write_data_array = 1'b0;
    bus.write_tag_array  = 1'b0;
    bus.fill_address     = '0;
    if (state == BUSY) begin
      bus.fsm_busy         = 1'b1;
      bus.mem_en           = issue;
      bus.memory_address   = line_base | ADDR_W'({issue_cnt[IDX_W-1:0], 1'b0});
      bus.write_data_array = ret;
      bus.fill_address     = line_base | ADDR_W'({ret_cnt, 1'b0});
      bus.write_tag_array  = last_ret;
    end
  end

  assign bus.fill_data = bus.memory_data;

endmodule

// File: doc/cache_fill_fsm.md
# cache_fill_fsm

Miss-handling engine between the cache and the multi-cycle main memory (`memory4c`). It accepts a miss on a 16-bit byte address and issues one memory read per word of the aligned cache line, back to back. It writes each returning word into the cache data array and then writes the tag once the last word has arrived. Downstream it drives the memory enable and address ports; upstream it holds the pipeline via `fsm_busy`.

## Interface
- `WORDS_PER_LINE`, default 8: 16-bit words per line. Must be a power of 2; the line is `2*WORDS_PER_LINE` bytes.
- `ADDR_W`, default 16: byte-address width.
- `clk` input, 1 bit: system clock. All state updates on the rising edge.
- `rst_n` input, 1 bit: reset, asynchronous assertion, active low.
- `miss_detected` input, 1 bit: cache miss request. Sampled only in IDLE.
- `miss_address` input, ADDR_W bits: byte address of the missing access. Captured with `miss_detected`.
- `memory_data_valid` input, 1 bit: memory returns one word this cycle, in issue order.
- `memory_data` input, 16 bits: returned word.
- `fsm_busy` output, 1 bit: fill in progress; the pipeline stalls.
- `mem_en` output, 1 bit: memory read request this cycle.
- `memory_address` output, ADDR_W bits: request address; valid when `mem_en`=1.
- `write_data_array` output, 1 bit: write `fill_data` at `fill_address` into the data array.
- `write_tag_array` output, 1 bit: one-cycle pulse to write the tag for `line_base`.
- `fill_address` output, ADDR_W bits: byte address of the word being written.
- `fill_data` output, 16 bits: equals `memory_data`, passed through combinationally.

## Operation
- **States:** IDLE, BUSY.
- **Registers:**
  - `line_base`, ADDR_W bits: `miss_address` with the low log2(2*WORDS_PER_LINE) bits cleared.
  - `issue_cnt`, 0..WORDS_PER_LINE.
  - `ret_cnt`, 0..WORDS_PER_LINE-1.
- **IDLE → BUSY:** on a cycle where `miss_detected`=1. On that edge: capture `line_base`, clear `issue_cnt` and `ret_cnt`.
- **In BUSY:**
  - `fsm_busy`=1.
  - `mem_en`=1 while `issue_cnt`<WORDS_PER_LINE.
  - `memory_address` = `line_base` + 2*`issue_cnt`.
  - `issue_cnt` increments on each issue and saturates at WORDS_PER_LINE; no further requests are issued after that.
- **Return path, when `memory_data_valid`=1 in BUSY:**
  - `write_data_array`=1.
  - `fill_address` = `line_base` + 2*`ret_cnt`.
  - `ret_cnt` increments.
- **BUSY → IDLE:** when `memory_data_valid`=1 and `ret_cnt`=WORDS_PER_LINE-1. In that same cycle `write_tag_array`=1.
- **Address arithmetic:** modulo 2^ADDR_W. A line at the top of memory (e.g. 0xFFF0) stays inside the line because `line_base` is aligned; no carry out.
- **Ignored inputs:**
  - `miss_detected` while in BUSY, including the final cycle. A new miss is accepted only in IDLE.
  - `memory_data_valid` in IDLE: no write, no state change.
- **Outputs in IDLE:** `mem_en`, `write_data_array`, `write_tag_array`, `fsm_busy` are all 0. `memory_address` and `fill_address` are 0.

## Timing
- **Reset:** `rst_n`=0 forces IDLE and clears all counters and `line_base` immediately, without waiting for a clock edge. Consequences:
  - All outputs go to 0 (`fill_data` follows `memory_data`).
  - Reset during BUSY abandons the fill: no tag write, and no further data writes even if memory still returns words.
- **Issue latency:** the miss is seen at edge 0 and BUSY starts at edge 0. Requests go out in the cycles after edge 0 through edge 7, one word per cycle, with no gaps.
- **Return latency:** with memory latency L cycles from request to valid, word k returns L cycles after request k.
  - Last data write and tag pulse occur in cycle 7+L of BUSY, counting the first BUSY cycle as 0.
  - `fsm_busy` falls at the following edge. Total occupancy: WORDS_PER_LINE + L cycles (12 for L=4).
- **Simultaneous events:** a request and a return can occur in the same cycle; both are handled.
- **Back-to-back misses:** a miss asserted in the first IDLE cycle after a fill starts a new fill at that edge; no dead cycle is required beyond that one.
- `write_tag_array` is high for exactly one cycle per completed fill.

## Test plan
- **Reset values:** apply reset, then release with no stimulus → all outputs 0 and state IDLE for 10 cycles.
- **Single miss:** miss at 0x1234, memory latency 4 →
  - `memory_address` steps 0x1230, 0x1232 … 0x123E with `mem_en` high for exactly 8 consecutive cycles.
  - Writes go to `fill_address` 0x1230..0x123E with matching data.
  - `write_tag_array` pulses once, together with the 8th write.
  - `fsm_busy` is high for 12 cycles.
- **Top-of-memory wrap:** miss at 0xFFFF → addresses 0xFFF0..0xFFFE, never 0x0000.
- **Ignored inputs:** pulse `miss_detected` mid-fill and `memory_data_valid` while idle → no extra requests, no writes, and `line_base` is unchanged.
- **Reset mid-fill:** pull `rst_n` low after the 3rd return →
  - Outputs clear immediately with no `write_tag_array`.
  - Late valids after reset release cause no writes.
  - A fresh miss at 0x0040 then completes normally.
- **Back-to-back fills:** a miss at 0x2000, then a miss at 0x3008 the first cycle after `fsm_busy` falls → two complete fills. Tags are written for 0x2000 and 0x3000.
